pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage RV64 pipeline. Each cycle it sees decode-stage source registers, EX-stage load/jump/debug status and the data-memory handshake. It drives per-register stall and flush strobes for PC, IF/ID, ID/EX and EX/MEM. A small FSM sequences multi-cycle events: data-memory wait with timeout, post-redirect fetch bubbles, and debug halt/resume.

## Interface
Parameters:
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before the access is abandoned; range 1..65535.
- REDIRECT_BUBBLES, 1: extra IF/ID flush cycles after a redirect, covering synchronous imem latency; range 0..3.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- rs1_ID, rs2_ID  in  5  source fields of the instruction in IF/ID
- rd_EX  in  5  destination of the instruction in EX
- rf_wr_en_EX  in  1  EX instruction writes the register file
- dm_rd_ctrl_EX  in  3  nonzero = EX instruction is a load
- do_jump_EX  in  1  taken jump/branch resolved in EX
- is_debug_EX  in  1  debug instruction in EX
- dbg_resume  in  1  single-cycle resume pulse from the debug host
- dmem_req  in  1  MEM stage has a data-memory access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- stall_PC, stall_IFID, stall_IDEX, stall_EXMEM  out  1  hold the register
- flush_IFID, flush_IDEX  out  1  load a bubble; flush overrides stall on the same register
- halted  out  1  core halted for debug
- mem_timeout  out  1  sticky, set when a wait reaches MEM_TIMEOUT
- state_o  out  2  RUN=0, MEM_WAIT=1, REDIRECT=2, HALT=3

## Operation
Strobes are combinational from the current state and inputs. Evaluation uses the priority list below; all applicable lines apply, unless a line says otherwise.
- Memory wait (any state): `dmem_req && !dmem_ready` asserts all four stalls. Transition RUN→MEM_WAIT. The wait counter increments each such cycle.
- MEM_WAIT:
  - Stall all four while waiting.
  - On `dmem_ready`: stalls low that cycle, next state RUN, counter cleared, rules 2–4 evaluated the same cycle.
  - When the counter reaches MEM_TIMEOUT: set mem_timeout, stalls low, counter cleared, next state RUN. The access is abandoned.
- Redirect (RUN or REDIRECT, no memory wait): `do_jump_EX` asserts flush_IFID and flush_IDEX.
  - If REDIRECT_BUBBLES>0: enter REDIRECT with bubble counter = REDIRECT_BUBBLES.
  - REDIRECT asserts flush_IFID each cycle and decrements the counter. At 0, next state RUN.
  - The counter freezes during a memory wait.
  - A new `do_jump_EX` restarts the counter.
- Debug (RUN, no memory wait, no jump): `is_debug_EX` asserts stall_PC, stall_IFID and flush_IDEX, then enters HALT.
  - HALT asserts stall_PC, stall_IFID and flush_IDEX every cycle, with halted=1. EX/MEM drains normally.
  - `dbg_resume` → next state RUN, with halted=1 still in that cycle.
  - dbg_resume outside HALT is ignored.
- Load-use (RUN only, otherwise idle): applies when `dm_rd_ctrl_EX!=0 && rf_wr_en_EX && rd_EX!=0 && (rd_EX==rs1_ID || rd_EX==rs2_ID)`. Asserts stall_PC, stall_IFID and flush_IDEX for exactly one cycle. No state change.
- Counters saturate at neither boundary. Widths are $clog2(MEM_TIMEOUT+1) and 2 bits.

## Timing
- Reset (asynchronous, active-low): state RUN, all strobes 0, halted 0, mem_timeout 0, counters 0, state_o 0. Reset mid-wait or mid-halt aborts it immediately.
- Strobe latency: 0 cycles, input→output in the same cycle. State and counters update on the rising clk edge.
- Load-use costs 1 bubble. A redirect costs 2 + REDIRECT_BUBBLES flushed slots.
- A memory wait of N cycles stalls for N cycles. At timeout, stalls drop in the cycle after the MEM_TIMEOUT-th wait cycle.
- Simultaneous memory wait + jump: the stall wins. The jump is re-evaluated after release, because the EX contents are held.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cnt[31:0], counting cycles with stall_PC=1.
  - Adds outputs flush_cnt[31:0], counting cycles with flush_IDEX=1.
  - Both counters wrap modulo 2^32 and reset to 0.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Load-use: rd_EX=5, dm_rd_ctrl_EX=3, rf_wr_en_EX=1, rs2_ID=5 → one cycle of stall_PC=stall_IFID=flush_IDEX=1, state_o stays 0. Same stimulus with rd_EX=0 → no strobes.
- Jump, REDIRECT_BUBBLES=1: pulse do_jump_EX → cycle 0: flush_IFID=flush_IDEX=1. Cycle 1: flush_IFID=1 only, state_o=2. Cycle 2: state_o=0.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles → all stalls high for 3 cycles, state_o=1. Stalls drop the cycle ready=1.
- Timeout, MEM_TIMEOUT=4: ready held low → after 4 wait cycles mem_timeout=1 (sticky), stalls drop, state_o=0. mem_timeout clears only on reset.
- Debug: is_debug_EX=1 → halted=1, stall_PC/IFID and flush_IDEX held for 10 cycles. dbg_resume pulse → state_o=0 the next cycle. Reset asserted mid-halt → all outputs 0 asynchronously.
- With HAZARD_PERF_CNT_EN: the load-use scenario plus the 3-cycle memory wait → stall_cnt=4, flush_cnt=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV64 pipeline: load-use, redirect bubbles,
// data-memory wait with timeout and debug halt. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT      = 255,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic [4:0]  rd_EX,
    input  logic        rf_wr_en_EX,
    input  logic [2:0]  dm_rd_ctrl_EX,
    input  logic        do_jump_EX,
    input  logic        is_debug_EX,
    input  logic        dbg_resume,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_PC,
    output logic        stall_IFID,
    output logic        stall_IDEX,
    output logic        stall_EXMEM,
    output logic        flush_IFID,
    output logic        flush_IDEX,
    output logic        halted,
    output logic        mem_timeout,
    output logic [1:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t         state, state_nx;
    logic [WCW-1:0] wait_cnt, wait_cnt_nx;
    logic [1:0]     bub_cnt, bub_cnt_nx;
    logic           mem_wait, timeout_hit, holding, load_use;

    assign mem_wait    = dmem_req && !dmem_ready;
    // Once the wait has lasted MEM_TIMEOUT cycles the access is dropped and the pipe flows.
    assign timeout_hit = mem_wait && (wait_cnt == WCW'(MEM_TIMEOUT));
    assign holding     = mem_wait && !timeout_hit;
    assign load_use    = (dm_rd_ctrl_EX != 3'd0) && rf_wr_en_EX && (rd_EX != 5'd0) &&
                         ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            bub_cnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            bub_cnt  <= bub_cnt_nx;
            if (timeout_hit)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = '0;
        bub_cnt_nx  = bub_cnt;
        if (holding) begin
            // Redirect and halt keep their place; only RUN moves to MEM_WAIT.
            wait_cnt_nx = wait_cnt + 1'b1;
            if (state == RUN)
                state_nx = MEM_WAIT;
        end else begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    state_nx = RUN;
                    if (do_jump_EX) begin
                        if (REDIRECT_BUBBLES > 0) begin
                            state_nx   = REDIRECT;
                            bub_cnt_nx = 2'(REDIRECT_BUBBLES);
                        end
                    end else if (is_debug_EX) begin
                        state_nx = HALT;
                    end
                end
                REDIRECT: begin
                    if (do_jump_EX) begin
                        bub_cnt_nx = 2'(REDIRECT_BUBBLES);
                    end else begin
                        bub_cnt_nx = bub_cnt - 2'd1;
                        if (bub_cnt == 2'd1)
                            state_nx = RUN;
                    end
                end
                HALT: ;
            endcase
        end
        // A resume pulse is single-cycle, so it is honoured even under a memory stall.
        if (state == HALT && dbg_resume)
            state_nx = RUN;
    end

    always_comb begin
        stall_PC    = 1'b0;
        stall_IFID  = 1'b0;
        stall_IDEX  = 1'b0;
        stall_EXMEM = 1'b0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        if (reset) begin
            if (holding) begin
                stall_PC    = 1'b1;
                stall_IFID  = 1'b1;
                stall_IDEX  = 1'b1;
                stall_EXMEM = 1'b1;
            end else begin
                unique case (state)
                    RUN, MEM_WAIT: begin
                        if (do_jump_EX) begin
                            flush_IFID = 1'b1;
                            flush_IDEX = 1'b1;
                        end else if (is_debug_EX || load_use) begin
                            stall_PC   = 1'b1;
                            stall_IFID = 1'b1;
                            flush_IDEX = 1'b1;
                        end
                    end
                    REDIRECT: begin
                        flush_IFID = 1'b1;
                        flush_IDEX = do_jump_EX;
                    end
                    HALT: begin
                        stall_PC   = 1'b1;
                        stall_IFID = 1'b1;
                        flush_IDEX = 1'b1;
                    end
                endcase
            end
        end
    end

    assign halted  = (state == HALT);
    assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_PC)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_IDEX)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand sequences for halt/reset,
// then randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT      = 4;
    localparam int REDIRECT_BUBBLES = 1;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LU   = 6'b110001;
    localparam logic [5:0] ST4  = 6'b111100;
    localparam logic [5:0] JMP  = 6'b000011;
    localparam logic [5:0] BUB  = 6'b000010;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       rf_wr_en_EX;
    logic [2:0] dm_rd_ctrl_EX;
    logic       do_jump_EX, is_debug_EX, dbg_resume, dmem_req, dmem_ready;
    logic       stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX;
    logic       halted, mem_timeout;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT     (MEM_TIMEOUT),
        .REDIRECT_BUBBLES(REDIRECT_BUBBLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rd_EX        (rd_EX),
        .rf_wr_en_EX  (rf_wr_en_EX),
        .dm_rd_ctrl_EX(dm_rd_ctrl_EX),
        .do_jump_EX   (do_jump_EX),
        .is_debug_EX  (is_debug_EX),
        .dbg_resume   (dbg_resume),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .stall_PC     (stall_PC),
        .stall_IFID   (stall_IFID),
        .stall_IDEX   (stall_IDEX),
        .stall_EXMEM  (stall_EXMEM),
        .flush_IFID   (flush_IFID),
        .flush_IDEX   (flush_IDEX),
        .halted       (halted),
        .mem_timeout  (mem_timeout),
        .state_o      (state_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic [2:0] ld;
        logic       jmp;
        logic       dbg;
        logic       res;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    wire [9:0] act = {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX,
                      halted, mem_timeout, state_o};

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    // Reference model: pipeline mode, consecutive wait cycles, bubbles left, sticky timeout.
    int m_mode, m_waited, m_left;
    bit m_to;
    int unsigned m_stall, m_flush;

    function automatic in_t idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t lu_in(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic wr, input logic [2:0] ld);
        in_t v = '0;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.wr = wr; v.ld = ld;
        return v;
    endfunction

    function automatic in_t ctl(input logic jmp, input logic dbg, input logic res,
                                input logic req, input logic rdy);
        in_t v = '0;
        v.jmp = jmp; v.dbg = dbg; v.res = res; v.req = req; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [9:0] ex(input logic [5:0] s, input logic h, input logic t,
                                      input logic [1:0] st);
        return {s, h, t, st};
    endfunction

    task automatic add(input in_t v, input logic [9:0] e);
        vec_t r;
        r.in = v; r.exp = e;
        vq.push_back(r);
    endtask

    task automatic drive(input in_t v);
        rs1_ID = v.rs1; rs2_ID = v.rs2; rd_EX = v.rd; rf_wr_en_EX = v.wr;
        dm_rd_ctrl_EX = v.ld; do_jump_EX = v.jmp; is_debug_EX = v.dbg;
        dbg_resume = v.res; dmem_req = v.req; dmem_ready = v.rdy;
    endtask

    task automatic check(input string nm, input logic [9:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b (strobes,halted,timeout,state)", nm, act, e);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic run_cycle(input in_t v, input logic [9:0] e, input string nm);
        drive(v);
        @(negedge clk);
        check(nm, e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(idle());
        reset = 1'b0;
        #2;
        check("reset_state", 10'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        m_mode = 0; m_waited = 0; m_left = 0; m_to = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic logic [9:0] model_out(input in_t v);
        logic [5:0] s;
        bit hold_now, flowing, hz;
        hold_now = v.req && !v.rdy && (m_waited < MEM_TIMEOUT);
        flowing  = (m_mode == 0) || (m_mode == 1);
        hz       = (v.ld != 3'd0) && v.wr && (v.rd != 5'd0) && (v.rd == v.rs1 || v.rd == v.rs2);
        if (hold_now)                  s = ST4;
        else if (m_mode == 3)          s = LU;
        else if (v.jmp)                s = JMP;
        else if (m_mode == 2)          s = BUB;
        else if (flowing && (v.dbg || hz)) s = LU;
        else                           s = NONE;
        return {s, m_mode == 3, m_to, 2'(m_mode)};
    endfunction

    task automatic model_step(input in_t v, input logic [9:0] o);
        bit wreq, was_halt;
        wreq     = v.req && !v.rdy;
        was_halt = (m_mode == 3);
        if (o[9]) m_stall++;
        if (o[4]) m_flush++;
        if (wreq && m_waited == MEM_TIMEOUT) m_to = 1'b1;
        if (wreq && m_waited < MEM_TIMEOUT) begin
            m_waited++;
            if (m_mode == 0) m_mode = 1;
        end else begin
            m_waited = 0;
            if (m_mode == 0 || m_mode == 1) begin
                if (v.jmp) begin
                    m_left = REDIRECT_BUBBLES;
                    m_mode = (REDIRECT_BUBBLES > 0) ? 2 : 0;
                end else if (v.dbg) m_mode = 3;
                else m_mode = 0;
            end else if (m_mode == 2) begin
                if (v.jmp) m_left = REDIRECT_BUBBLES;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        end
        if (was_halt && v.res) m_mode = 0;
    endtask

    initial begin
        in_t  v;
        logic [9:0] e;
        int burst;

        // Directed vectors; each row is one cycle and state carries between rows.
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(lu_in(5, 0, 5, 1, 3),    ex(LU,   0, 0, 2'd0));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(lu_in(0, 0, 5, 1, 3),    ex(NONE, 0, 0, 2'd0));
        add(ctl(1, 0, 0, 0, 0),      ex(JMP,  0, 0, 2'd0));
        add(idle(),                  ex(BUB,  0, 0, 2'd2));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd0));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd1));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd1));
        add(ctl(0, 0, 0, 1, 1),      ex(NONE, 0, 0, 2'd1));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(ctl(1, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd0));
        add(ctl(1, 0, 0, 1, 1),      ex(JMP,  0, 0, 2'd1));
        add(idle(),                  ex(BUB,  0, 0, 2'd2));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(ctl(1, 0, 0, 0, 0),      ex(JMP,  0, 0, 2'd0));
        add(lu_in(5, 0, 5, 1, 3),    ex(BUB,  0, 0, 2'd2));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(ctl(1, 0, 0, 0, 0),      ex(JMP,  0, 0, 2'd0));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd2));
        add(idle(),                  ex(BUB,  0, 0, 2'd2));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(ctl(1, 0, 0, 0, 0),      ex(JMP,  0, 0, 2'd0));
        add(ctl(1, 0, 0, 0, 0),      ex(JMP,  0, 0, 2'd2));
        add(idle(),                  ex(BUB,  0, 0, 2'd2));
        add(idle(),                  ex(NONE, 0, 0, 2'd0));
        add(lu_in(7, 7, 0, 1, 1),    ex(LU,   0, 0, 2'd0));
        add(lu_in(7, 7, 0, 0, 1),    ex(NONE, 0, 0, 2'd0));
        add(lu_in(7, 7, 0, 1, 0),    ex(NONE, 0, 0, 2'd0));
        add(ctl(0, 0, 1, 0, 0),      ex(NONE, 0, 0, 2'd0));
        // Timeout after MEM_TIMEOUT=4 wait cycles, then sticky flag.
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd0));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd1));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd1));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 0, 2'd1));
        add(ctl(0, 0, 0, 1, 0),      ex(NONE, 0, 0, 2'd1));
        add(idle(),                  ex(NONE, 0, 1, 2'd0));
        add(idle(),                  ex(NONE, 0, 1, 2'd0));
        add(ctl(0, 0, 0, 1, 0),      ex(ST4,  0, 1, 2'd0));
        add(ctl(0, 0, 0, 1, 1),      ex(NONE, 0, 1, 2'd1));
        add(idle(),                  ex(NONE, 0, 1, 2'd0));

        do_reset();
        for (int i = 0; i < vq.size(); i++)
            run_cycle(vq[i].in, vq[i].exp, $sformatf("vec%0d", i));

        // Debug halt: ten held cycles, resume, then a reset landing mid-halt.
        do_reset();
        run_cycle(ctl(0, 1, 0, 0, 0), ex(LU, 0, 0, 2'd0), "dbg_enter");
        for (int i = 0; i < 10; i++)
            run_cycle(idle(), ex(LU, 1, 0, 2'd3), $sformatf("dbg_hold%0d", i));
        run_cycle(ctl(0, 0, 1, 0, 0), ex(LU, 1, 0, 2'd3), "dbg_resume");
        run_cycle(idle(), ex(NONE, 0, 0, 2'd0), "dbg_after");
        run_cycle(ctl(0, 1, 0, 0, 0), ex(LU, 0, 0, 2'd0), "dbg_enter2");
        drive(idle());
        #2;
        check("halt_held", ex(LU, 1, 0, 2'd3));
        reset = 1'b0;
        #1;
        check("async_reset_mid_halt", 10'd0);
        @(posedge clk); #1;
        reset = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        run_cycle(lu_in(5, 0, 5, 1, 3), ex(LU, 0, 0, 2'd0), "perf_lu");
        run_cycle(ctl(0, 0, 0, 1, 0), ex(ST4, 0, 0, 2'd0), "perf_w0");
        run_cycle(ctl(0, 0, 0, 1, 0), ex(ST4, 0, 0, 2'd1), "perf_w1");
        run_cycle(ctl(0, 0, 0, 1, 0), ex(ST4, 0, 0, 2'd1), "perf_w2");
        run_cycle(ctl(0, 0, 0, 1, 1), ex(NONE, 0, 0, 2'd1), "perf_rdy");
        check32("stall_cnt", stall_cnt, 32'd4);
        check32("flush_cnt", flush_cnt, 32'd1);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        burst = 0;
        for (int c = 0; c < 1500; c++) begin
            v = '0;
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.wr  = 1'($urandom_range(0, 1));
            v.ld  = 3'($urandom_range(0, 2));
            v.jmp = ($urandom_range(0, 9) == 0);
            v.dbg = ($urandom_range(0, 19) == 0);
            v.res = ($urandom_range(0, 4) == 0);
            if (burst == 0 && $urandom_range(0, 5) == 0)
                burst = int'($urandom_range(1, 7));
            v.req = (burst > 0);
            v.rdy = (burst == 1);
            if (burst > 0) burst--;
            e = model_out(v);
            drive(v);
            @(negedge clk);
            check($sformatf("rand%0d", c), e);
            model_step(v, e);
            @(posedge clk); #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        check32("rand_stall_cnt", stall_cnt, 32'(m_stall));
        check32("rand_flush_cnt", flush_cnt, 32'(m_flush));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
